mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single MemReadWrite port (instruction and data in one array) between three requesters: instruction fetch, data load/store, and the inference readout path. Each requester uses a req/ack handshake. The arbiter grants one access at a time, drives the memory enables/address/data, waits the fixed read latency, returns read data, and pulses ack. It replaces the ad-hoc mem_en/mem_ren/mem_wen sequencing and RED wait states inside the processor control FSM.

Parameters:
ADDR_W, 16, memory word-address width
DATA_W, 32, memory data width
READ_LAT, 3, cycles from the first cycle mem_en/mem_ren is driven to the edge that samples valid mem_dout; legal range 1..15

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request (read only)
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse, access done
dm_req  in  1  data request
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  one-cycle pulse, access done
inf_req  in  1  inference readout request (read only)
inf_addr  in  ADDR_W  readout address (offset already applied by requester)
inf_ack  out  1  one-cycle pulse, access done
rdata  out  DATA_W  captured read data, valid while any ack is high, held until the next read capture
busy  out  1  high in every state except IDLE
grant_id  out  2  0 none, 1 fetch, 2 data, 3 inference; registered with the grant
mem_en  out  1  memory enable
mem_ren  out  1  memory read enable
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_din  out  DATA_W  memory write data
mem_dout  in  DATA_W  memory read data

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0, including rdata, grant_id, and the latency counter. An in-flight access is abandoned and no ack is issued.
- Requester rule: hold req, addr, we, and wdata stable until ack; drop req in the cycle after ack. If req drops early, the granted access still completes and its ack still pulses.
- States: IDLE, RD_WAIT, WR, RESP.
- IDLE: at an edge with any req high, select the winner (fixed priority dm > if > inf) and register grant_id, mem_addr, mem_en=1.
  - Store: mem_wen=1, mem_din=dm_wdata, go to WR.
  - Load/read: mem_ren=1, counter=READ_LAT-1, go to RD_WAIT.
- WR: lasts exactly one cycle with mem_wen high. At the next edge: mem_en=mem_wen=0, winner's ack=1, go to RESP.
- RD_WAIT: mem_en and mem_ren held high. The counter decrements each edge. At the edge where the counter equals 0: rdata<=mem_dout, mem_en=mem_ren=0, winner's ack=1, go to RESP.
- RESP: one cycle, ack high, no new grant evaluated. At the next edge: ack=0, grant_id=0, go to IDLE.
- Latency from the accepting edge E0:
  - Write ack is high in the cycle after E0+1.
  - Read ack is high in the cycle after E0+READ_LAT.
  - With READ_LAT=3, a back-to-back read costs 5 cycles including IDLE.
- If dm_we is high while dm_req is low, it is ignored. Fetch and inference are never writes.
- Requests arriving while busy wait; no request is lost while its req stays high.
- Addresses are passed through unmodified; there is no wrap or bounds check.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: rotating priority. A last-winner register (reset to data) makes the requester after the last winner highest priority, order dm -> if -> inf -> dm.
- Undefined: fixed priority dm > if > inf; no last-winner register.

Decomposition:
- Shared package mem_arb_pkg: requester ID localparams (ID_NONE=0, ID_IF=1, ID_DM=2, ID_INF=3) and the state encoding (2 bits).
- One sub-module, arb_pick: combinational winner select from the three reqs plus the last-winner ID, returning the grant ID. Only the rotating mode uses the last-winner input.

Test Plan:
- Single fetch, if_addr=0x0005, mem_dout model returns 0x2002000A after 3 cycles: if_ack pulses once 3 cycles after acceptance, rdata=0x2002000A, mem_ren high 3 cycles.
- Store, dm_we=1, dm_addr=0x1000, dm_wdata=0xDEADBEEF: mem_wen high exactly one cycle with mem_din=0xDEADBEEF, dm_ack the next cycle, rdata unchanged.
- if_req, dm_req, and inf_req all raised on the same edge, fixed mode: grant order data, fetch, inference, each with one ack. RR mode after a prior data grant: order fetch, inference, data.
- Reset_n pulsed low mid-RD_WAIT: all outputs 0 immediately and no ack. After release, with req still high, the access restarts and completes.
- dm_req dropped one cycle after acceptance: access completes, dm_ack still pulses, no second grant. inf_req asserted during RESP is granted only after RESP.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: requester IDs and FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Requester IDs; these values also appear on grant_id.
  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_IF   = 2'd1;
  localparam logic [1:0] ID_DM   = 2'd2;
  localparam logic [1:0] ID_INF  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR      = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select among fetch, data and inference requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; losers simply keep their req high and are picked later.
// Ports: if_req/dm_req/inf_req - requests; last_id - previous winner (the
//        requester after it gets top priority); grant - winning ID or ID_NONE.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       inf_req,
  input  logic [1:0] last_id,
  output logic [1:0] grant
);

  // Rotation order is dm -> if -> inf -> dm. A last_id of inf (or none)
  // yields the plain dm > if > inf order, which is how fixed mode is built.
  always_comb begin
    grant = ID_NONE;
    case (last_id)
      ID_DM: begin
        if (if_req)       grant = ID_IF;
        else if (inf_req) grant = ID_INF;
        else if (dm_req)  grant = ID_DM;
      end
      ID_IF: begin
        if (inf_req)      grant = ID_INF;
        else if (dm_req)  grant = ID_DM;
        else if (if_req)  grant = ID_IF;
      end
      default: begin
        if (dm_req)       grant = ID_DM;
        else if (if_req)  grant = ID_IF;
        else if (inf_req) grant = ID_INF;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one read/write memory port between fetch, data and inference requesters.
// Latency: store ack in the cycle after E0+1, read ack in the cycle after E0+READ_LAT (E0 = accepting edge).
// Backpressure: one access at a time; other requesters hold req until their ack.
// Ports: clk/reset_n; {if,dm,inf}_req/_addr plus dm_we/dm_wdata in; one-cycle
//        {if,dm,inf}_ack out; rdata (held until next read); busy; grant_id;
//        mem_en/mem_ren/mem_wen/mem_addr/mem_din out, mem_dout in.
// Build option: define MEM_ARB_RR_EN for rotating priority (default fixed dm > if > inf).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 3     // legal 1..15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  input  logic              inf_req,
  input  logic [ADDR_W-1:0] inf_addr,
  output logic              inf_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic              mem_en,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [1:0]        grant_nxt;
  logic              en_nxt, ren_nxt, wen_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt, rdata_nxt;
  logic [1:0]        last_id;
  logic [1:0]        pick_id;

`ifdef MEM_ARB_RR_EN
  logic [1:0] last_q;

  // Remember who won so the next requester in rotation gets first pick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_q <= ID_DM;
    else if (state == ST_IDLE && pick_id != ID_NONE)
      last_q <= pick_id;
  end

  assign last_id = last_q;
`else
  // Rotation after inf is dm > if > inf, i.e. plain fixed priority.
  assign last_id = ID_INF;
`endif

  arb_pick u_pick (
    .if_req  (if_req),
    .dm_req  (dm_req),
    .inf_req (inf_req),
    .last_id (last_id),
    .grant   (pick_id)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      grant_id <= ID_NONE;
      mem_en   <= 1'b0;
      mem_ren  <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      grant_id <= grant_nxt;
      mem_en   <= en_nxt;
      mem_ren  <= ren_nxt;
      mem_wen  <= wen_nxt;
      mem_addr <= addr_nxt;
      mem_din  <= din_nxt;
      rdata    <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_nxt = grant_id;
    en_nxt    = mem_en;
    ren_nxt   = mem_ren;
    wen_nxt   = mem_wen;
    addr_nxt  = mem_addr;
    din_nxt   = mem_din;
    rdata_nxt = rdata;
    case (state)
      ST_IDLE: begin
        if (pick_id != ID_NONE) begin
          grant_nxt = pick_id;
          en_nxt    = 1'b1;
          case (pick_id)
            ID_IF:   addr_nxt = if_addr;
            ID_DM:   addr_nxt = dm_addr;
            default: addr_nxt = inf_addr;
          endcase
          // dm_we only matters when the data requester actually wins.
          if (pick_id == ID_DM && dm_we) begin
            wen_nxt   = 1'b1;
            din_nxt   = dm_wdata;
            state_nxt = ST_WR;
          end else begin
            ren_nxt   = 1'b1;
            cnt_nxt   = 4'(READ_LAT - 1);
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_WR: begin
        en_nxt    = 1'b0;
        wen_nxt   = 1'b0;
        state_nxt = ST_RESP;
      end
      ST_RD_WAIT: begin
        if (cnt == 4'd0) begin
          rdata_nxt = mem_dout;
          en_nxt    = 1'b0;
          ren_nxt   = 1'b0;
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        grant_nxt = ID_NONE;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Acks come straight from registered state, so they are glitch-free and
  // last exactly the single RESP cycle.
  assign if_ack  = (state == ST_RESP) && (grant_id == ID_IF);
  assign dm_ack  = (state == ST_RESP) && (grant_id == ID_DM);
  assign inf_ack = (state == ST_RESP) && (grant_id == ID_INF);
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-checking memory model.
// Latency: memory read data is only valid after mem_ren has been held READ_LAT cycles.
// Backpressure: requesters hold req until ack, as the arbiter expects.
module tb_mem_port_arbiter;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        if_req, dm_req, dm_we, inf_req;
  logic [15:0] if_addr, dm_addr, inf_addr;
  logic [31:0] dm_wdata;
  logic        if_ack, dm_ack, inf_ack;
  logic [31:0] rdata;
  logic        busy;
  logic [1:0]  grant_id;
  logic        mem_en, mem_ren, mem_wen;
  logic [15:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(RL)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .inf_req(inf_req), .inf_addr(inf_addr), .inf_ack(inf_ack),
    .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Memory model, indexed by the low address byte; preloaded while in reset.
  logic [31:0] mem [0:255];
  int          ren_run;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h05:   init_val = 32'h2002000A;
      8'h42:   init_val = 32'h12345678;
      default: init_val = {24'hA5A5A5, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (mem_en && mem_wen) begin
      mem[mem_addr[7:0]] <= mem_din;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                ren_run <= 0;
    else if (mem_en && mem_ren)  ren_run <= ren_run + 1;
    else                         ren_run <= 0;
  end

  assign mem_dout = (mem_en && mem_ren && ren_run >= RL - 1) ? mem[mem_addr[7:0]] : 32'hBADBAD00;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int ack_code();
    case ({inf_ack, dm_ack, if_ack})
      3'b000:  ack_code = 0;
      3'b001:  ack_code = 1;
      3'b010:  ack_code = 2;
      3'b100:  ack_code = 3;
      default: ack_code = 7;
    endcase
  endfunction

  task automatic clear_reqs;
    if_req = 1'b0; dm_req = 1'b0; inf_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; inf_addr = '0; dm_wdata = '0;
  endtask

  task automatic set_req(input int who, input logic we, input logic [15:0] a, input logic [31:0] wd);
    case (who)
      1: begin if_req = 1'b1; if_addr = a; end
      2: begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; end
      default: begin inf_req = 1'b1; inf_addr = a; end
    endcase
  endtask

  task automatic drop_req(input int who);
    case (who)
      1: if_req = 1'b0;
      2: begin dm_req = 1'b0; dm_we = 1'b0; end
      default: inf_req = 1'b0;
    endcase
  endtask

  // Tick until some ack appears (bounded); report what the memory port did.
  task automatic wait_ack(output int id, output int lat, output int wen_n, output int ren_n,
                          output logic [15:0] seen_addr, output logic [31:0] seen_din);
    id = 0; lat = 0; wen_n = 0; ren_n = 0; seen_addr = '0; seen_din = '0;
    for (int i = 0; i < 50; i++) begin
      tick;
      lat++;
      if (mem_wen) begin wen_n++; seen_din = mem_din; end
      if (mem_ren) ren_n++;
      if (mem_en) seen_addr = mem_addr;
      id = ack_code();
      if (id != 0) break;
    end
  endtask

  typedef struct {
    int          who;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        stray_we;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wen;
    int          exp_ren;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          id, lat, wn, rn;
    logic [15:0] sa;
    logic [31:0] sd;
    int          exp_order [3];
    logic [31:0] exp_data [4];
    int          extra;

    //            who we addr      wdata         stray rdata          lat     wen ren
    vecs[0] = '{1, 1'b0, 16'h0005, 32'h0,        1'b0, 32'h2002000A, RL + 1, 0, RL};
    vecs[1] = '{2, 1'b1, 16'h1000, 32'hDEADBEEF, 1'b0, 32'h2002000A, 2,      1, 0};
    vecs[2] = '{2, 1'b0, 16'h1000, 32'h0,        1'b0, 32'hDEADBEEF, RL + 1, 0, RL};
    vecs[3] = '{3, 1'b0, 16'h0042, 32'h0,        1'b0, 32'h12345678, RL + 1, 0, RL};
    vecs[4] = '{2, 1'b1, 16'h0007, 32'h0BADF00D, 1'b0, 32'h12345678, 2,      1, 0};
    vecs[5] = '{3, 1'b0, 16'h0107, 32'h0,        1'b0, 32'h0BADF00D, RL + 1, 0, RL};
    vecs[6] = '{1, 1'b0, 16'h1000, 32'h0,        1'b1, 32'hDEADBEEF, RL + 1, 0, RL};

    clear_reqs();
    #2 reset_n = 1'b0;
    repeat (3) tick;
    check("reset_ctrl", {busy, grant_id, mem_en, mem_ren, mem_wen, if_ack, dm_ack, inf_ack}, 64'h0);
    check("reset_addr", mem_addr, 64'h0);
    check("reset_din", mem_din, 64'h0);
    check("reset_rdata", rdata, 64'h0);
    reset_n = 1'b1;
    tick;

    // Single-requester transactions.
    for (int v = 0; v < 7; v++) begin
      clear_reqs();
      set_req(vecs[v].who, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      if (vecs[v].stray_we) dm_we = 1'b1;
      wait_ack(id, lat, wn, rn, sa, sd);
      check($sformatf("v%0d_ack_id", v), id, vecs[v].who);
      check($sformatf("v%0d_grant", v), grant_id, vecs[v].who);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_wen_cycles", v), wn, vecs[v].exp_wen);
      check($sformatf("v%0d_ren_cycles", v), rn, vecs[v].exp_ren);
      check($sformatf("v%0d_mem_addr", v), sa, vecs[v].addr);
      if (vecs[v].we) check($sformatf("v%0d_mem_din", v), sd, vecs[v].wdata);
      check($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
      tick;
      check($sformatf("v%0d_ack_once", v), ack_code(), 0);
      check($sformatf("v%0d_idle", v), {busy, grant_id}, 3'b000);
      clear_reqs();
    end

    // Prior data grant, then all three requesters on the same edge.
    set_req(2, 1'b0, 16'h1000, 32'h0);
    wait_ack(id, lat, wn, rn, sa, sd);
    check("prior_dm_ack", id, 2);
    tick;
    clear_reqs();
`ifdef MEM_ARB_RR_EN
    exp_order = '{1, 3, 2};
`else
    exp_order = '{2, 1, 3};
`endif
    exp_data[0] = 32'h0;
    exp_data[1] = 32'h2002000A;
    exp_data[2] = 32'hDEADBEEF;
    exp_data[3] = 32'h12345678;
    set_req(1, 1'b0, 16'h0005, 32'h0);
    set_req(2, 1'b0, 16'h1000, 32'h0);
    set_req(3, 1'b0, 16'h0042, 32'h0);
    for (int k = 0; k < 3; k++) begin
      wait_ack(id, lat, wn, rn, sa, sd);
      check($sformatf("multi%0d_order", k), id, exp_order[k]);
      check($sformatf("multi%0d_rdata", k), rdata, exp_data[exp_order[k]]);
      check($sformatf("multi%0d_latency", k), lat, (k == 0) ? RL + 1 : RL + 2);
      if (id >= 1 && id <= 3) drop_req(id);
    end
    tick;
    check("multi_done_idle", busy, 1'b0);
    clear_reqs();
    tick;

    // Data request dropped right after acceptance still completes once.
    set_req(2, 1'b0, 16'h1000, 32'h0);
    tick;
    check("drop_granted", {busy, grant_id}, {1'b1, 2'd2});
    drop_req(2);
    wait_ack(id, lat, wn, rn, sa, sd);
    check("drop_ack_id", id, 2);
    check("drop_latency", lat, RL);
    check("drop_rdata", rdata, 32'hDEADBEEF);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (busy || ack_code() != 0) extra++;
    end
    check("drop_no_regrant", extra, 0);

    // Inference request raised during RESP waits for IDLE.
    set_req(1, 1'b0, 16'h0005, 32'h0);
    wait_ack(id, lat, wn, rn, sa, sd);
    check("resp_if_ack", id, 1);
    drop_req(1);
    set_req(3, 1'b0, 16'h0042, 32'h0);
    tick;
    check("resp_no_grant", {busy, grant_id}, 3'b000);
    tick;
    check("resp_inf_grant", {busy, grant_id}, {1'b1, 2'd3});
    wait_ack(id, lat, wn, rn, sa, sd);
    check("resp_inf_ack", id, 3);
    check("resp_inf_rdata", rdata, 32'h12345678);
    tick;
    clear_reqs();
    tick;

    // Reset in the middle of a read wait.
    set_req(1, 1'b0, 16'h0005, 32'h0);
    tick;
    tick;
    check("pre_reset_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {busy, grant_id, mem_en, mem_ren, mem_wen, if_ack, dm_ack, inf_ack}, 64'h0);
    check("midrst_rdata", rdata, 64'h0);
    check("midrst_addr", mem_addr, 64'h0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (ack_code() != 0 || busy) extra++;
    end
    check("midrst_no_ack", extra, 0);
    reset_n = 1'b1;
    wait_ack(id, lat, wn, rn, sa, sd);
    check("rst_restart_ack", id, 1);
    check("rst_restart_lat", lat, RL + 1);
    check("rst_restart_rdata", rdata, 32'h2002000A);
    tick;
    clear_reqs();
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
